context_switcher: RTL

CONTEXT_SWITCHER -- requirements
Module: context_switcher

---
 rtl/context_switcher_pkg.sv | 31 +++
 rtl/context_switcher.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/context_switcher_pkg.sv
// context_switcher_pkg
//   Shared definitions for the context save/restore engine: FSM state
//   encoding, register-file write location codes, the frame indices that
//   hold HI and LO, and the frame address helper ctx_addr_gen.
package context_switcher_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SV_RD = 3'd1,
        ST_SV_WR = 3'd2,
        ST_RS_RD = 3'd3,
        ST_RS_WR = 3'd4,
        ST_DONE  = 3'd5
    } ctx_state_e;

    localparam logic [2:0] LOC_GPR = 3'b000;
    localparam logic [2:0] LOC_HI  = 3'b011;
    localparam logic [2:0] LOC_LO  = 3'b100;

    // Frame layout: words 0..31 are GPRs, then HI, then LO.
    localparam logic [5:0] IDX_HI = 6'd32;
    localparam logic [5:0] IDX_LO = 6'd33;

    // Byte address of frame word idx; wraps modulo 2^32 by construction.
    function automatic logic [31:0] ctx_addr_gen(input logic [31:0] base,
                                                 input logic [5:0]  idx,
                                                 input int unsigned stride);
        return base + stride * {26'b0, idx};
    endfunction

endpackage

// File: rtl/context_switcher.sv
// context_switcher
//   Saves the 32 GPRs plus HI/LO to a memory frame (mode=0) or restores them
//   from it (mode=1). One frame word moves every two cycles.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   start, mode, base_addr request (sampled in IDLE), direction, frame address
//   busy, done            non-IDLE indicator, one-cycle completion pulse
//   rf_raddr, rf_rdata    GPR read port (data one cycle after address)
//   rf_hi, rf_lo          current HI / LO values
//   rf_we, rf_loc, rf_waddr, rf_wdata   register-file write port
//   mem_addr, mem_wdata, mem_we, mem_re, mem_rdata   memory port
module context_switcher
    import context_switcher_pkg::*;
#(
    parameter int unsigned WORD_BYTES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        mode,
    input  logic [31:0] base_addr,
    output logic        busy,
    output logic        done,
    output logic [4:0]  rf_raddr,
    input  logic [31:0] rf_rdata,
    input  logic [31:0] rf_hi,
    input  logic [31:0] rf_lo,
    output logic        rf_we,
    output logic [2:0]  rf_loc,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [31:0] mem_rdata
);

    ctx_state_e  state_q, state_d;
    logic [5:0]  idx_q, idx_d;
    logic [31:0] base_q, base_d;
    logic        busy_q, busy_d, done_q, done_d;
    logic        mem_we_q, mem_we_d, mem_re_q, mem_re_d, rf_we_q, rf_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [4:0]  rf_raddr_q, rf_raddr_d, rf_waddr_q, rf_waddr_d;
    logic [2:0]  rf_loc_q, rf_loc_d;

    // Next state, then control outputs decoded from the *next* state so the
    // registered outputs line up with the state they belong to.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        base_d  = base_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    base_d = base_addr & 32'hFFFF_FFFC;
                    if (mode) begin
                        idx_d   = 6'd1;   // r0 is never restored
                        state_d = ST_RS_RD;
                    end else begin
                        idx_d   = 6'd0;
                        state_d = ST_SV_RD;
                    end
                end
            end
            ST_SV_RD: state_d = ST_SV_WR;
            ST_SV_WR: begin
                if (idx_q == IDX_LO) state_d = ST_DONE;
                else begin
                    idx_d   = idx_q + 6'd1;
                    state_d = ST_SV_RD;
                end
            end
            ST_RS_RD: state_d = ST_RS_WR;
            ST_RS_WR: begin
                if (idx_q == IDX_LO) state_d = ST_DONE;
                else begin
                    idx_d   = idx_q + 6'd1;
                    state_d = ST_RS_RD;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_d == ST_DONE);
        mem_we_d   = (state_d == ST_SV_WR);
        mem_re_d   = (state_d == ST_RS_RD);
        rf_we_d    = (state_d == ST_RS_WR);
        mem_addr_d = (mem_we_d || mem_re_d) ?
                     ctx_addr_gen(base_d, idx_d, WORD_BYTES) : 32'h0;
        rf_raddr_d = (state_d == ST_SV_RD) ? idx_d[4:0] : 5'd0;
        rf_loc_d   = LOC_GPR;
        rf_waddr_d = 5'd0;
        if (rf_we_d) begin
            if (idx_d == IDX_HI)      rf_loc_d = LOC_HI;
            else if (idx_d == IDX_LO) rf_loc_d = LOC_LO;
            else                      rf_waddr_d = idx_d[4:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= 6'd0;
            base_q     <= 32'h0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_re_q   <= 1'b0;
            rf_we_q    <= 1'b0;
            mem_addr_q <= 32'h0;
            rf_raddr_q <= 5'd0;
            rf_waddr_q <= 5'd0;
            rf_loc_q   <= LOC_GPR;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            base_q     <= base_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            mem_we_q   <= mem_we_d;
            mem_re_q   <= mem_re_d;
            rf_we_q    <= rf_we_d;
            mem_addr_q <= mem_addr_d;
            rf_raddr_q <= rf_raddr_d;
            rf_waddr_q <= rf_waddr_d;
            rf_loc_q   <= rf_loc_d;
        end
    end

    // Write data arrives during the write cycle itself (rf_rdata / mem_rdata
    // lag their address by one cycle), so these muxes stay combinational,
    // gated by the current state so they read zero whenever reset holds IDLE.
    always_comb begin
        mem_wdata = 32'h0;
        rf_wdata  = 32'h0;
        if (state_q == ST_SV_WR) begin
            if (idx_q == IDX_HI)      mem_wdata = rf_hi;
            else if (idx_q == IDX_LO) mem_wdata = rf_lo;
            else                      mem_wdata = rf_rdata;
        end
        if (state_q == ST_RS_WR) rf_wdata = mem_rdata;
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign mem_we   = mem_we_q;
    assign mem_re   = mem_re_q;
    assign rf_we    = rf_we_q;
    assign mem_addr = mem_addr_q;
    assign rf_raddr = rf_raddr_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_loc   = rf_loc_q;

endmodule
